ping_sequencer: RTL and testbench
=================================

Name: ping_sequencer

Overview:
- Measurement controller for one ultrasonic transducer channel; sits directly upstream of echo_counter.
- Fires the sensor trigger pulse and synchronises the raw echo input. Drives echo_pulse and enable_count into echo_counter.
- Samples distance_raw when the echo ends and presents one qualified result per ping, or a timeout code if no echo returns.
- Supports single-shot (start) and free-running (auto_mode) operation with an enforced hold-off between pings.

Parameters:
- TRIG_CYCLES, 200, trigger high time in clk cycles (10 us at 20 MHz).
- TIMEOUT_CYCLES, 480000, maximum cycles from trigger end to echo end before the ping is declared lost (24 ms).
- HOLDOFF_CYCLES, 1200000, dead time after each ping before the next trigger (60 ms).
- TIMER_W, 24, width of the internal shared timer. Must hold max(TRIG_CYCLES, TIMEOUT_CYCLES, HOLDOFF_CYCLES).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-shot request, level sampled in IDLE.
- auto_mode  input  1  1 = re-trigger automatically after hold-off.
- echo_in  input  1  raw echo from the sensor, asynchronous.
- distance_raw  input  16  count from echo_counter.
- trigger  output  1  sensor trigger pulse.
- echo_pulse  output  1  synchronised echo to echo_counter.
- enable_count  output  1  count enable to echo_counter.
- distance_out  output  16  last result.
- distance_valid  output  1  one-cycle strobe, distance_out updated.
- timeout  output  1  one-cycle strobe coincident with distance_valid when the ping was lost.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE, timer 0, sync flops 0. All outputs 0, including distance_out=16'h0000.
- Echo sync: echo_in passes through two flops to give echo_sync. echo_pulse = echo_sync. echo_sync_d is a third register used for edge detection.
  - rise = echo_sync & ~echo_sync_d
  - fall = ~echo_sync & echo_sync_d
- IDLE:
  - Exits when start=1 or auto_mode=1. On that edge: state TRIG, timer cleared.
  - trigger rises on that same edge, so the first cycle high is the cycle after start is sampled.
- TRIG:
  - trigger=1 for exactly TRIG_CYCLES cycles.
  - When timer==TRIG_CYCLES-1: state WAIT_ECHO, timer cleared.
- WAIT_ECHO:
  - enable_count=1; timer increments.
  - A rise moves to MEASURE; the timer keeps running.
  - An echo already high on entry gives no rise and does not count.
- MEASURE:
  - enable_count=1; timer increments.
  - A fall moves to CAPTURE.
- CAPTURE (1 cycle):
  - enable_count=0.
  - distance_out <= distance_raw, distance_valid=1, timeout=0.
  - Then HOLDOFF, timer cleared.
- Timeout:
  - Applies in WAIT_ECHO or MEASURE when timer==TIMEOUT_CYCLES-1 and the current cycle has no rise/fall transition.
  - distance_out <= 16'hFFFF, distance_valid=1, timeout=1, enable_count=0.
  - Then HOLDOFF, timer cleared.
  - Simultaneous timeout and fall: fall wins and the ping goes to CAPTURE.
- HOLDOFF:
  - Lasts HOLDOFF_CYCLES cycles.
  - At the end: TRIG if auto_mode=1, else IDLE.
  - Echo edges here are ignored.
- General rules:
  - start outside IDLE is ignored, not queued.
  - Clearing auto_mode mid-ping lets the current ping complete, then returns to IDLE.
  - distance_out holds its value between strobes.
  - The timer saturates rather than wraps; with a legal TIMER_W wrap is unreachable.
  - Reset asserted mid-ping aborts immediately: trigger and enable_count drop asynchronously, no strobe is issued.

Test Plan (TRIG_CYCLES=4, TIMEOUT_CYCLES=100, HOLDOFF_CYCLES=20):
- Reset, start=1 for 1 cycle -> trigger high exactly 4 cycles, then enable_count=1, busy=1.
- After trigger, echo_in high 30 cycles, distance_raw driven to 16'd1234 -> distance_out=1234, one distance_valid pulse, timeout=0. echo_pulse lags echo_in by 2 cycles. Returns to IDLE 20 cycles after the strobe.
- No echo -> 100 cycles after trigger end: distance_out=16'hFFFF, distance_valid=1, timeout=1, enable_count=0.
- auto_mode=1, echo of 10 cycles per ping -> back-to-back pings. Next trigger rises exactly 20 cycles after each strobe. Three strobes observed; start toggles during busy have no effect.
- echo_in held high before and through trigger -> no rise, so the ping times out (16'hFFFF). Separately: a fall landing on the timeout cycle -> CAPTURE result, not 16'hFFFF.
- reset pulled low mid-MEASURE -> all outputs 0 asynchronously, no strobe. After release, start gives a normal ping.

Source files
------------

// File: rtl/ping_sequencer.sv
// Ultrasonic ping controller: fires the trigger, syncs the echo and
// qualifies one distance result (or timeout code) per ping.
module ping_sequencer #(
    parameter int TRIG_CYCLES    = 200,
    parameter int TIMEOUT_CYCLES = 480000,
    parameter int HOLDOFF_CYCLES = 1200000,
    parameter int TIMER_W        = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        auto_mode,
    input  logic        echo_in,
    input  logic [15:0] distance_raw,
    output logic        trigger,
    output logic        echo_pulse,
    output logic        enable_count,
    output logic [15:0] distance_out,
    output logic        distance_valid,
    output logic        timeout,
    output logic        busy
);

    localparam logic [TIMER_W-1:0] TRIG_LAST = TIMER_W'(TRIG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TO_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        CAPTURE,
        HOLDOFF
    } state_t;

    state_t             state, state_nx;
    logic [TIMER_W-1:0] timer, timer_nx;
    logic               echo_meta, echo_sync, echo_sync_d;
    logic               rise, fall, lost;

    assign rise = echo_sync & ~echo_sync_d;
    assign fall = ~echo_sync & echo_sync_d;

    // Two-flop synchroniser plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo_meta   <= 1'b0;
            echo_sync   <= 1'b0;
            echo_sync_d <= 1'b0;
        end else begin
            echo_meta   <= echo_in;
            echo_sync   <= echo_meta;
            echo_sync_d <= echo_sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = (&timer) ? timer : timer + 1'b1;
        lost     = 1'b0;
        unique case (state)
            IDLE: begin
                timer_nx = '0;
                if (start || auto_mode) state_nx = TRIG;
            end
            TRIG: begin
                if (timer == TRIG_LAST) begin
                    state_nx = WAIT_ECHO;
                    timer_nx = '0;
                end
            end
            WAIT_ECHO: begin
                if (rise) begin
                    state_nx = MEASURE;
                end else if (timer >= TO_LAST) begin
                    lost     = 1'b1;
                    state_nx = HOLDOFF;
                    timer_nx = '0;
                end
            end
            MEASURE: begin
                // A fall on the last timeout cycle still yields a real result
                if (fall) begin
                    state_nx = CAPTURE;
                end else if (timer >= TO_LAST) begin
                    lost     = 1'b1;
                    state_nx = HOLDOFF;
                    timer_nx = '0;
                end
            end
            CAPTURE: begin
                state_nx = HOLDOFF;
                timer_nx = '0;
            end
            HOLDOFF: begin
                if (timer >= HOLD_LAST) begin
                    state_nx = auto_mode ? TRIG : IDLE;
                    timer_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    // Result and strobes are registered together so they line up
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            distance_out   <= 16'h0000;
            distance_valid <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            distance_valid <= (state == CAPTURE) || lost;
            timeout        <= lost;
            if (state == CAPTURE) begin
                distance_out <= distance_raw;
            end else if (lost) begin
                distance_out <= 16'hFFFF;
            end
        end
    end

    assign trigger      = (state == TRIG);
    assign enable_count = (state == WAIT_ECHO) || (state == MEASURE);
    assign busy         = (state != IDLE);
    assign echo_pulse   = echo_sync;

endmodule

// File: tb/tb_ping_sequencer.sv
// Scoreboard bench for ping_sequencer: directed pings with
// hand-computed results and timing.
`timescale 1ns/1ps
module tb_ping_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        auto_mode = 1'b0;
    logic        echo_in = 1'b0;
    logic [15:0] distance_raw = 16'h0000;
    logic        trigger, echo_pulse, enable_count;
    logic [15:0] distance_out;
    logic        distance_valid, timeout, busy;

    int checks = 0;
    int failures = 0;
    logic [16:0] sb[$];

    ping_sequencer #(
        .TRIG_CYCLES(4),
        .TIMEOUT_CYCLES(100),
        .HOLDOFF_CYCLES(20),
        .TIMER_W(24)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .auto_mode(auto_mode),
        .echo_in(echo_in),
        .distance_raw(distance_raw),
        .trigger(trigger),
        .echo_pulse(echo_pulse),
        .enable_count(enable_count),
        .distance_out(distance_out),
        .distance_valid(distance_valid),
        .timeout(timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected result
    always @(negedge clk) begin
        if (reset && distance_valid) begin
            logic [16:0] e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: got %0h/%0b expected none",
                         distance_out, timeout);
            end else begin
                e = sb.pop_front();
                if ({timeout, distance_out} !== e) begin
                    failures++;
                    $display("FAIL result: got to=%0b dist=%0h expected to=%0b dist=%0h",
                             timeout, distance_out, e[16], e[15:0]);
                end
            end
        end
        if (reset && timeout && !distance_valid) begin
            checks++;
            failures++;
            $display("FAIL lone_timeout: got timeout=1 expected 0 without strobe");
        end
    end

    task automatic trig_len(output int cnt);
        cnt = 0;
        while (trigger && cnt < 50) begin
            step();
            cnt++;
        end
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!distance_valid && n < 300) begin
            step();
            n++;
        end
        check(name, distance_valid, 1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic wait_trig(output int n);
        n = 0;
        while (!trigger && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic fire();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int n, t;
        logic [15:0] vals[3];
        vals[0] = 16'd111;
        vals[1] = 16'd222;
        vals[2] = 16'd333;

        #3;
        check("rst_trigger", trigger, 0);
        check("rst_enable", enable_count, 0);
        check("rst_busy", busy, 0);
        check("rst_dist", distance_out, 0);
        check("rst_valid", distance_valid, 0);
        check("rst_echo", echo_pulse, 0);
        step();
        reset = 1'b1;
        step();

        // Single-shot ping, 30-cycle echo
        fire();
        check("p1_trig_first", trigger, 1);
        trig_len(n);
        check("p1_trig_len", n, 4);
        check("p1_enable", enable_count, 1);
        check("p1_busy", busy, 1);
        distance_raw = 16'd1234;
        sb.push_back({1'b0, 16'd1234});
        echo_in = 1'b1;
        step();
        check("p1_lag1", echo_pulse, 0);
        step();
        check("p1_lag2", echo_pulse, 1);
        repeat (28) step();
        echo_in = 1'b0;
        wait_valid("p1_strobe", n);
        check("p1_strobe_time", n + 30, 34);
        check("p1_enable_off", enable_count, 0);
        wait_idle(n);
        check("p1_holdoff", n, 20);

        // No echo: lost ping
        sb.push_back({1'b1, 16'hFFFF});
        fire();
        trig_len(n);
        check("p2_trig_len", n, 4);
        wait_valid("p2_strobe", n);
        check("p2_timeout_time", n, 100);
        check("p2_timeout", timeout, 1);
        check("p2_enable_off", enable_count, 0);
        wait_idle(n);

        // Free-running pings, start toggled while busy
        auto_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_trig(n);
            check("p3_trig_gap", n, (i == 0) ? 1 : 20);
            trig_len(n);
            check("p3_trig_len", n, 4);
            distance_raw = vals[i];
            sb.push_back({1'b0, vals[i]});
            echo_in = 1'b1;
            for (int k = 0; k < 10; k++) begin
                start = k[0];
                step();
            end
            start = 1'b0;
            echo_in = 1'b0;
            wait_valid("p3_strobe", n);
            if (i == 2) auto_mode = 1'b0;
        end
        wait_idle(n);
        check("p3_to_idle", n, 20);

        // Echo already high through trigger: no rise, times out
        echo_in = 1'b1;
        repeat (3) step();
        sb.push_back({1'b1, 16'hFFFF});
        fire();
        trig_len(n);
        check("p4_trig_len", n, 4);
        repeat (20) step();
        echo_in = 1'b0;
        wait_valid("p4_strobe", t);
        check("p4_timeout_time", t + 20, 100);
        wait_idle(n);

        // Fall lands on the timeout cycle: real result wins
        distance_raw = 16'd4321;
        sb.push_back({1'b0, 16'd4321});
        fire();
        trig_len(n);
        echo_in = 1'b1;
        repeat (97) step();
        echo_in = 1'b0;
        wait_valid("p5_strobe", t);
        check("p5_capture_time", t + 97, 101);
        check("p5_no_timeout", timeout, 0);
        wait_idle(n);

        // Reset mid-measure aborts without a strobe
        distance_raw = 16'd999;
        fire();
        trig_len(n);
        echo_in = 1'b1;
        repeat (10) step();
        check("p6_measuring", enable_count, 1);
        #2;
        reset = 1'b0;
        #1;
        check("p6_trigger", trigger, 0);
        check("p6_enable", enable_count, 0);
        check("p6_busy", busy, 0);
        check("p6_dist", distance_out, 0);
        check("p6_valid", distance_valid, 0);
        check("p6_echo", echo_pulse, 0);
        echo_in = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        distance_raw = 16'd777;
        sb.push_back({1'b0, 16'd777});
        fire();
        trig_len(n);
        check("p7_trig_len", n, 4);
        echo_in = 1'b1;
        repeat (5) step();
        echo_in = 1'b0;
        wait_valid("p7_strobe", n);
        wait_idle(n);
        repeat (3) step();
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
